counter_cfg_sequencer: RTL and testbench
========================================

# counter_cfg_sequencer

Host-side controller for the 8-bit up/down counter's register bus. It takes one configuration request (PLR, ULR, LLR, CCR) and validates the limits. It then performs the four register writes over the ncs/nwr/A1/A0/din bus, pulses start, and monitors the run until ec or err. It also arbitrates host count read-backs into the bus when no write sequence is in progress.

## Interface
- `DATA_W`, default 8, width of the counter data bus and all register values.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  host requests a configuration run; held until accepted.
- `cfg_ready`  out  1  high only in IDLE and ERR; transfer occurs when `cfg_valid & cfg_ready`.
- `plr_in`, `ulr_in`, `llr_in`, `ccr_in`  in  DATA_W each  preload, upper limit, lower limit and control values.
- `rd_req`  in  1  count read request; a level held until `rd_valid`.
- `rd_data`  out  DATA_W  captured count value.
- `rd_valid`  out  1  one-cycle pulse, `rd_data` valid.
- `abort`  in  1  synchronous abort of any sequence.
- `done`  out  1  one-cycle pulse, the run ended on ec.
- `err_flag`  out  1  sticky; set on limit violation or counter err.
- `cnt_ncs`, `cnt_nwr`, `cnt_nrd`  out  1 each  counter bus strobes, active-low.
- `cnt_a1`, `cnt_a0`  out  1 each  register address.
- `cnt_dout`  out  DATA_W  write data.
- `cnt_doe`  out  1  tristate enable for `cnt_dout` onto the shared din bus; the tristate buffer lives at top level.
- `cnt_din`  in  DATA_W  value read back from the bus.
- `cnt_start`  out  1  counter start.
- `cnt_ec`, `cnt_err`  in  1 each  end-of-count and error from the counter.

## Operation
- **Reset values:** ncs, nwr and nrd are 1. doe, start, a1, a0, rd_valid and done are 0. dout and rd_data are 0. err_flag is 0. State is IDLE.
- **Addresses:** PLR=00, ULR=01, LLR=10, CCR=11. Count read-back uses A=00 with nrd=0.
- **Accept:** on `cfg_valid & cfg_ready`, the four inputs are latched into shadow registers and err_flag is cleared.
  - The block checks `llr < ulr` and `llr <= plr <= ulr`, unsigned.
  - If the check fails: go to ERR, set err_flag, and perform no bus activity.
- **FSM states:** IDLE, W_SETUP, W_STROBE, START, RUN, R_SETUP, R_SAMPLE, ERR.
  - A write index (0..3) walks PLR, ULR, LLR, CCR.
  - W_SETUP: ncs=0, doe=1, address and data driven, nwr=1.
  - W_STROBE: nwr=0 with address and data held.
  - After index 3, go to START.
  - START: start=1 for exactly one cycle, then RUN.
  - RUN: ncs=0 and start=0.
    - On sampled cnt_ec: done pulses next cycle, then go to IDLE.
    - On sampled cnt_err: go to ERR and set err_flag.
- **Reads:**
  - rd_req is serviced only in IDLE or RUN: R_SETUP (ncs=0, nrd=0, A=00, doe=0), then R_SAMPLE.
  - rd_data is latched from cnt_din at the end of R_SAMPLE, and rd_valid pulses the next cycle.
  - Afterwards, return to the state the read came from.
  - A rd_req raised during a write sequence stays pending until RUN.
- **Boundaries:**
  - cfg_valid and rd_req together in IDLE: cfg wins.
  - cnt_ec or cnt_err seen during R_SETUP or R_SAMPLE: latched as pending and acted on after the read completes.
  - ec and err in the same cycle: err wins; no done pulse.
  - abort: next state is IDLE, all strobes return to reset values, no done pulse, and err_flag is unchanged. Abort wins over ec, err and cfg_valid in the same cycle.
  - ERR: strobes are idle; the state is left only by a new accepted cfg or by abort.
  - Reset asserted mid-sequence: all outputs take their reset values immediately (asynchronous).
- **Invariants:**
  - doe and nrd=0 are never active together.
  - nwr is low only while ncs is low.

## Timing
- Accept edge is T0. Write strobes (nwr=0) occur in cycles T2, T4, T6 and T8, at A = 00, 01, 10, 11. start is high in T9, and RUN begins at T10.
- Address and data are stable one full cycle before nwr falls and during the nwr-low cycle.
- **Read latency:** rd_req sampled at cycle R, nrd low in R+1 and R+2, rd_valid at R+3.
- **Completion:** done asserts the cycle after cnt_ec is sampled high in RUN.

## Structure
- **Shared header/package `counter_bus_defs`:** address constants ADDR_PLR, ADDR_ULR, ADDR_LLR, ADDR_CCR and ADDR_CNT; FSM state encodings; DATA_W default. The up/down counter uses the same header.
- **Sub-module `cnt_bus_xact`:** a two-cycle single-transaction bus engine.
  - Inputs: go, rw, addr, wdata. Outputs: the strobes, doe, rdata, xact_done.
  - counter_cfg_sequencer sequences and arbitrates transactions into it.

## Test plan
- **Valid config:** plr=100, ulr=150, llr=50, ccr=2. Expect nwr low at T2/4/6/8 with A=00/01/10/11 and dout 100/150/50/2, start high at T9 only, then RUN. cnt_ec at T20 → done at T21, cfg_ready=1 at T22.
- **Bad limits:** ulr=5, llr=15. Expect no strobe activity, state ERR, err_flag=1, cfg_ready=1. A following valid cfg clears err_flag.
- **Read in RUN:** rd_req with cnt_din=8'h37 → nrd low two cycles with doe=0, rd_valid with rd_data=8'h37 three cycles later. An ec pulse during R_SAMPLE still yields done after the read.
- **Abort:** abort at T5 (mid LLR write) → ncs, nwr and nrd all high at T6, no start, cfg_ready=1.
- **Counter err in RUN:** cnt_err=1 → err_flag=1, state ERR, no done. With ec and err together, still no done.
- **Async reset:** reset low at T7 → all outputs at reset values in the same cycle; after release, a new cfg sequence completes normally.

Source files
------------

// File: rtl/counter_cfg_sequencer_pkg.sv
// Shared definitions for the up/down counter register bus: addresses, widths and the
// state encodings used by the host-side sequencer and its bus transaction engine.
package counter_bus_defs;

    localparam int unsigned DATA_W_DEFAULT = 8;

    localparam logic [1:0] ADDR_PLR = 2'b00;
    localparam logic [1:0] ADDR_ULR = 2'b01;
    localparam logic [1:0] ADDR_LLR = 2'b10;
    localparam logic [1:0] ADDR_CCR = 2'b11;
    localparam logic [1:0] ADDR_CNT = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWStrobe,
        StStart,
        StRun,
        StRSetup,
        StRSample,
        StErr
    } seq_state_e;

    typedef enum logic [1:0] {
        PhIdle,
        PhSetup,
        PhStrobe
    } xact_phase_e;

endpackage

// File: rtl/cnt_bus_xact.sv
// Two-cycle single-transaction engine for the counter bus: a setup cycle with address and
// data presented, then a strobe cycle (nwr low for writes, read data captured at its end).
module cnt_bus_xact
    import counter_bus_defs::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              go,
    input  logic              rw,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              cnt_ncs,
    output logic              cnt_nwr,
    output logic              cnt_nrd,
    output logic              cnt_a1,
    output logic              cnt_a0,
    output logic [DATA_W-1:0] cnt_dout,
    output logic              cnt_doe,
    input  logic [DATA_W-1:0] cnt_din,
    output logic [DATA_W-1:0] rdata,
    output logic              xact_done
);

    xact_phase_e       phase_q, phase_d;
    logic              rw_q, rw_d;
    logic [1:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              active, wr_active, rd_active;

    always_comb begin
        phase_d = phase_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (clr) begin
            phase_d = PhIdle;
        end else begin
            if (phase_q == PhStrobe && rw_q) begin
                rdata_d = cnt_din;
            end
            // A new transaction may start in the strobe cycle of the previous one.
            if (go && phase_q != PhSetup) begin
                phase_d = PhSetup;
                rw_d    = rw;
                addr_d  = addr;
                wdata_d = wdata;
            end else if (phase_q == PhSetup) begin
                phase_d = PhStrobe;
            end else if (phase_q == PhStrobe) begin
                phase_d = PhIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PhIdle;
            rw_q    <= 1'b0;
            addr_q  <= 2'b00;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            phase_q <= phase_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        active    = (phase_q != PhIdle);
        wr_active = active && !rw_q;
        rd_active = active && rw_q;
        cnt_ncs   = !active;
        cnt_nwr   = !(wr_active && phase_q == PhStrobe);
        cnt_nrd   = !rd_active;
        cnt_doe   = wr_active;
        cnt_a1    = active ? addr_q[1] : 1'b0;
        cnt_a0    = active ? addr_q[0] : 1'b0;
        cnt_dout  = wr_active ? wdata_q : '0;
        rdata     = rdata_q;
        xact_done = (phase_q == PhStrobe);
    end

endmodule

// File: rtl/counter_cfg_sequencer.sv
// Host-side sequencer for the up/down counter: validates a configuration, writes the four
// registers, starts the counter, watches for ec/err and interleaves count read-backs.
module counter_cfg_sequencer
    import counter_bus_defs::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] plr_in,
    input  logic [DATA_W-1:0] ulr_in,
    input  logic [DATA_W-1:0] llr_in,
    input  logic [DATA_W-1:0] ccr_in,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              abort,
    output logic              done,
    output logic              err_flag,
    output logic              cnt_ncs,
    output logic              cnt_nwr,
    output logic              cnt_nrd,
    output logic              cnt_a1,
    output logic              cnt_a0,
    output logic [DATA_W-1:0] cnt_dout,
    output logic              cnt_doe,
    input  logic [DATA_W-1:0] cnt_din,
    output logic              cnt_start,
    input  logic              cnt_ec,
    input  logic              cnt_err
);

    seq_state_e        state_q, state_d;
    seq_state_e        ret_q, ret_d;
    logic [1:0]        idx_q, idx_d, idx_nxt;
    logic [DATA_W-1:0] plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d, ccr_q, ccr_d;
    logic              err_flag_q, err_flag_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ec_pend_q, ec_pend_d;
    logic              err_pend_q, err_pend_d;

    logic              go, go_rw;
    logic [1:0]        go_addr;
    logic [DATA_W-1:0] go_wdata;
    logic              eng_ncs, xact_done;
    logic              accept, limits_ok, ec_eff, err_eff;

    assign cfg_ready = (state_q == StIdle) || (state_q == StErr);
    assign accept    = cfg_valid && cfg_ready;
    assign limits_ok = (llr_in < ulr_in) && (llr_in <= plr_in) && (plr_in <= ulr_in);
    assign idx_nxt   = idx_q + 2'd1;
    assign ec_eff    = cnt_ec || ec_pend_q;
    assign err_eff   = cnt_err || err_pend_q;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        idx_d      = idx_q;
        plr_d      = plr_q;
        ulr_d      = ulr_q;
        llr_d      = llr_q;
        ccr_d      = ccr_q;
        err_flag_d = err_flag_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        ec_pend_d  = ec_pend_q;
        err_pend_d = err_pend_q;
        go         = 1'b0;
        go_rw      = 1'b0;
        go_addr    = ADDR_PLR;
        go_wdata   = '0;

        if (abort) begin
            state_d    = StIdle;
            ec_pend_d  = 1'b0;
            err_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StErr: begin
                    if (accept) begin
                        plr_d      = plr_in;
                        ulr_d      = ulr_in;
                        llr_d      = llr_in;
                        ccr_d      = ccr_in;
                        idx_d      = 2'd0;
                        ec_pend_d  = 1'b0;
                        err_pend_d = 1'b0;
                        if (limits_ok) begin
                            // First write launches straight from the inputs to save a cycle.
                            go         = 1'b1;
                            go_addr    = ADDR_PLR;
                            go_wdata   = plr_in;
                            err_flag_d = 1'b0;
                            state_d    = StWSetup;
                        end else begin
                            err_flag_d = 1'b1;
                            state_d    = StErr;
                        end
                    end else if (state_q == StIdle && rd_req && !rd_valid_q) begin
                        go      = 1'b1;
                        go_rw   = 1'b1;
                        go_addr = ADDR_CNT;
                        ret_d   = StIdle;
                        state_d = StRSetup;
                    end
                end
                StWSetup: begin
                    state_d = StWStrobe;
                end
                StWStrobe: begin
                    if (xact_done) begin
                        if (idx_q == 2'd3) begin
                            state_d = StStart;
                        end else begin
                            idx_d   = idx_nxt;
                            go      = 1'b1;
                            state_d = StWSetup;
                            case (idx_nxt)
                                2'd0: begin go_addr = ADDR_PLR; go_wdata = plr_q; end
                                2'd1: begin go_addr = ADDR_ULR; go_wdata = ulr_q; end
                                2'd2: begin go_addr = ADDR_LLR; go_wdata = llr_q; end
                                default: begin go_addr = ADDR_CCR; go_wdata = ccr_q; end
                            endcase
                        end
                    end
                end
                StStart: begin
                    state_d = StRun;
                end
                StRun: begin
                    // done_q high means the run already ended; this is the last RUN cycle.
                    if (done_q) begin
                        state_d = StIdle;
                    end else if (err_eff) begin
                        err_flag_d = 1'b1;
                        ec_pend_d  = 1'b0;
                        err_pend_d = 1'b0;
                        state_d    = StErr;
                    end else if (ec_eff) begin
                        done_d    = 1'b1;
                        ec_pend_d = 1'b0;
                    end else if (rd_req && !rd_valid_q) begin
                        go      = 1'b1;
                        go_rw   = 1'b1;
                        go_addr = ADDR_CNT;
                        ret_d   = StRun;
                        state_d = StRSetup;
                    end
                end
                StRSetup: begin
                    if (ret_q == StRun) begin
                        ec_pend_d  = ec_pend_q || cnt_ec;
                        err_pend_d = err_pend_q || cnt_err;
                    end
                    state_d = StRSample;
                end
                StRSample: begin
                    if (ret_q == StRun) begin
                        ec_pend_d  = ec_pend_q || cnt_ec;
                        err_pend_d = err_pend_q || cnt_err;
                    end
                    if (xact_done) begin
                        rd_valid_d = 1'b1;
                        state_d    = ret_q;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ret_q      <= StIdle;
            idx_q      <= 2'd0;
            plr_q      <= '0;
            ulr_q      <= '0;
            llr_q      <= '0;
            ccr_q      <= '0;
            err_flag_q <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            ec_pend_q  <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            idx_q      <= idx_d;
            plr_q      <= plr_d;
            ulr_q      <= ulr_d;
            llr_q      <= llr_d;
            ccr_q      <= ccr_d;
            err_flag_q <= err_flag_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            ec_pend_q  <= ec_pend_d;
            err_pend_q <= err_pend_d;
        end
    end

    cnt_bus_xact #(
        .DATA_W (DATA_W)
    ) u_xact (
        .clk       (clk),
        .reset     (reset),
        .clr       (abort),
        .go        (go),
        .rw        (go_rw),
        .addr      (go_addr),
        .wdata     (go_wdata),
        .cnt_ncs   (eng_ncs),
        .cnt_nwr   (cnt_nwr),
        .cnt_nrd   (cnt_nrd),
        .cnt_a1    (cnt_a1),
        .cnt_a0    (cnt_a0),
        .cnt_dout  (cnt_dout),
        .cnt_doe   (cnt_doe),
        .cnt_din   (cnt_din),
        .rdata     (rd_data),
        .xact_done (xact_done)
    );

    // The counter is held selected for the whole run so it keeps reporting ec/err.
    assign cnt_ncs   = eng_ncs && (state_q != StRun);
    assign cnt_start = (state_q == StStart);
    assign done      = done_q;
    assign rd_valid  = rd_valid_q;
    assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_counter_cfg_sequencer.sv
// Directed self-checking bench for counter_cfg_sequencer.
module tb_counter_cfg_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] plr_in = '0, ulr_in = '0, llr_in = '0, ccr_in = '0;
    logic       rd_req = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       abort = 1'b0;
    logic       done;
    logic       err_flag;
    logic       cnt_ncs, cnt_nwr, cnt_nrd, cnt_a1, cnt_a0, cnt_doe, cnt_start;
    logic [7:0] cnt_dout;
    logic [7:0] cnt_din = '0;
    logic       cnt_ec = 1'b0, cnt_err = 1'b0;

    int checks = 0;
    int failures = 0;

    // {ncs, nwr, nrd, doe, a1, a0}
    wire [5:0] bus = {cnt_ncs, cnt_nwr, cnt_nrd, cnt_doe, cnt_a1, cnt_a0};
    localparam logic [5:0] BUS_IDLE = 6'b111000;
    localparam logic [5:0] BUS_READ = 6'b010000;

    counter_cfg_sequencer #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .plr_in    (plr_in),
        .ulr_in    (ulr_in),
        .llr_in    (llr_in),
        .ccr_in    (ccr_in),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .abort     (abort),
        .done      (done),
        .err_flag  (err_flag),
        .cnt_ncs   (cnt_ncs),
        .cnt_nwr   (cnt_nwr),
        .cnt_nrd   (cnt_nrd),
        .cnt_a1    (cnt_a1),
        .cnt_a0    (cnt_a0),
        .cnt_dout  (cnt_dout),
        .cnt_doe   (cnt_doe),
        .cnt_din   (cnt_din),
        .cnt_start (cnt_start),
        .cnt_ec    (cnt_ec),
        .cnt_err   (cnt_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a config in the current cycle (T0) and advance to T10, the first RUN cycle.
    task automatic run_to_run(input logic [7:0] p, u, l, c);
        plr_in = p; ulr_in = u; llr_in = l; ccr_in = c;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (9) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) step();
        checks++; if (bus !== BUS_IDLE) begin failures++;
            $display("FAIL reset_bus got=%b exp=%b", bus, BUS_IDLE); end
        checks++; if ({cnt_start, done, rd_valid, err_flag, cfg_ready} !== 5'b00001) begin
            failures++; $display("FAIL reset_flags got=%b exp=00001",
                                 {cnt_start, done, rd_valid, err_flag, cfg_ready}); end
        checks++; if ({cnt_dout, rd_data} !== 16'h0000) begin failures++;
            $display("FAIL reset_data got=%h exp=0000", {cnt_dout, rd_data}); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_valid_cfg();
        logic [7:0] wd [4];
        logic [1:0] a;
        int start_hits = 0;
        wd[0] = 8'd100; wd[1] = 8'd150; wd[2] = 8'd50; wd[3] = 8'd2;
        plr_in = 8'd100; ulr_in = 8'd150; llr_in = 8'd50; ccr_in = 8'd2;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a = 2'(k);
            checks++; if (bus !== {4'b0111, a}) begin failures++;
                $display("FAIL valid_setup%0d bus got=%b exp=%b", k, bus, {4'b0111, a}); end
            checks++; if (cnt_dout !== wd[k]) begin failures++;
                $display("FAIL valid_setup%0d dout got=%0d exp=%0d", k, cnt_dout, wd[k]); end
            start_hits += int'(cnt_start);
            step();
            checks++; if (bus !== {4'b0011, a}) begin failures++;
                $display("FAIL valid_strobe%0d bus got=%b exp=%b", k, bus, {4'b0011, a}); end
            checks++; if (cnt_dout !== wd[k]) begin failures++;
                $display("FAIL valid_strobe%0d dout got=%0d exp=%0d", k, cnt_dout, wd[k]); end
            start_hits += int'(cnt_start);
            step();
        end
        // T9
        checks++; if ({cnt_start, bus} !== {1'b1, BUS_IDLE}) begin failures++;
            $display("FAIL valid_start_t9 got=%b exp=%b", {cnt_start, bus}, {1'b1, BUS_IDLE}); end
        step();
        // T10 .. T19
        for (int t = 10; t < 20; t++) begin
            start_hits += int'(cnt_start);
            if (t == 10) begin
                checks++; if ({cnt_ncs, cfg_ready, done} !== 3'b000) begin failures++;
                    $display("FAIL valid_run_t10 got=%b exp=000", {cnt_ncs, cfg_ready, done}); end
            end
            step();
        end
        checks++; if (start_hits !== 0) begin failures++;
            $display("FAIL valid_start_only_t9 extra_cycles got=%0d exp=0", start_hits); end
        cnt_ec = 1'b1;  // T20
        step();
        cnt_ec = 1'b0;  // T21
        checks++; if ({done, cfg_ready} !== 2'b10) begin failures++;
            $display("FAIL valid_done_t21 got=%b exp=10", {done, cfg_ready}); end
        step();         // T22
        checks++; if ({done, cfg_ready, err_flag} !== 3'b010) begin failures++;
            $display("FAIL valid_idle_t22 got=%b exp=010", {done, cfg_ready, err_flag}); end
    endtask

    task automatic test_bad_limits();
        int busy = 0;
        plr_in = 8'd10; ulr_in = 8'd5; llr_in = 8'd15; ccr_in = 8'd1;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if ({err_flag, cfg_ready} !== 2'b11) begin failures++;
            $display("FAIL bad_err got=%b exp=11", {err_flag, cfg_ready}); end
        rd_req = 1'b1;  // reads are not serviced in ERR
        for (int t = 0; t < 6; t++) begin
            busy += int'(bus !== BUS_IDLE || cnt_start !== 1'b0);
            step();
        end
        rd_req = 1'b0;
        checks++; if (busy !== 0) begin failures++;
            $display("FAIL bad_no_bus busy_cycles got=%0d exp=0", busy); end
        // Equal limits must also be rejected (llr < ulr is strict).
        plr_in = 8'd20; ulr_in = 8'd20; llr_in = 8'd20;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if ({err_flag, bus} !== {1'b1, BUS_IDLE}) begin failures++;
            $display("FAIL bad_equal got=%b exp=%b", {err_flag, bus}, {1'b1, BUS_IDLE}); end
        // A valid config from ERR clears the flag and starts writing.
        plr_in = 8'd20; ulr_in = 8'd30; llr_in = 8'd20;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if ({err_flag, bus} !== {1'b0, 6'b011100}) begin failures++;
            $display("FAIL bad_recover got=%b exp=%b", {err_flag, bus}, {1'b0, 6'b011100}); end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_read_run();
        run_to_run(8'd100, 8'd150, 8'd50, 8'd2);
        cnt_din = 8'h37;
        rd_req = 1'b1;   // R
        step();          // R+1
        checks++; if ({bus, rd_valid} !== {BUS_READ, 1'b0}) begin failures++;
            $display("FAIL rd_r1 got=%b exp=%b", {bus, rd_valid}, {BUS_READ, 1'b0}); end
        step();          // R+2
        checks++; if ({bus, rd_valid} !== {BUS_READ, 1'b0}) begin failures++;
            $display("FAIL rd_r2 got=%b exp=%b", {bus, rd_valid}, {BUS_READ, 1'b0}); end
        cnt_ec = 1'b1;   // ec during R_SAMPLE
        step();          // R+3
        cnt_ec = 1'b0;
        rd_req = 1'b0;
        checks++; if ({rd_valid, rd_data, done} !== {1'b1, 8'h37, 1'b0}) begin failures++;
            $display("FAIL rd_valid got=%b/%h/%b exp=1/37/0", rd_valid, rd_data, done); end
        step();          // R+4
        checks++; if ({done, rd_valid, cnt_nrd} !== 3'b101) begin failures++;
            $display("FAIL rd_pending_done got=%b exp=101", {done, rd_valid, cnt_nrd}); end
        step();
        checks++; if ({done, cfg_ready} !== 2'b01) begin failures++;
            $display("FAIL rd_idle got=%b exp=01", {done, cfg_ready}); end
    endtask

    task automatic test_back_to_back();
        int nrd_low = 0;
        // cfg and rd_req together in IDLE: the config wins, the read waits for RUN.
        plr_in = 8'd7; ulr_in = 8'd9; llr_in = 8'd3; ccr_in = 8'd1;
        cfg_valid = 1'b1;
        rd_req = 1'b1;
        cnt_din = 8'hA5;
        step();
        cfg_valid = 1'b0;
        checks++; if (bus !== 6'b011100) begin failures++;
            $display("FAIL b2b_cfg_wins got=%b exp=011100", bus); end
        for (int t = 1; t < 11; t++) begin  // T1..T10
            nrd_low += int'(!cnt_nrd);
            step();
        end
        checks++; if (nrd_low !== 0) begin failures++;
            $display("FAIL b2b_read_held nrd_low got=%0d exp=0", nrd_low); end
        checks++; if (bus !== BUS_READ) begin failures++;  // T11
            $display("FAIL b2b_read_t11 got=%b exp=%b", bus, BUS_READ); end
        step(); step();  // T13
        rd_req = 1'b0;
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin failures++;
            $display("FAIL b2b_rd_valid got=%b/%h exp=1/a5", rd_valid, rd_data); end
        step();
        checks++; if ({rd_valid, cnt_nrd, cnt_ncs} !== 3'b010) begin failures++;
            $display("FAIL b2b_single_read got=%b exp=010", {rd_valid, cnt_nrd, cnt_ncs}); end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        int start_hits = 0;
        plr_in = 8'd100; ulr_in = 8'd150; llr_in = 8'd50; ccr_in = 8'd2;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (4) step();  // T5: LLR setup
        checks++; if (bus !== 6'b011110) begin failures++;
            $display("FAIL abort_t5_llr got=%b exp=011110", bus); end
        abort = 1'b1;
        step();             // T6
        abort = 1'b0;
        checks++; if ({bus, cfg_ready} !== {BUS_IDLE, 1'b1}) begin failures++;
            $display("FAIL abort_t6 got=%b exp=%b", {bus, cfg_ready}, {BUS_IDLE, 1'b1}); end
        for (int t = 0; t < 6; t++) begin
            start_hits += int'(cnt_start);
            step();
        end
        checks++; if (start_hits !== 0) begin failures++;
            $display("FAIL abort_no_start got=%0d exp=0", start_hits); end
        // Abort wins over ec in RUN: no done pulse.
        run_to_run(8'd100, 8'd150, 8'd50, 8'd2);
        abort = 1'b1;
        cnt_ec = 1'b1;
        step();
        abort = 1'b0;
        cnt_ec = 1'b0;
        checks++; if ({done, cfg_ready, cnt_ncs, err_flag} !== 4'b0110) begin failures++;
            $display("FAIL abort_over_ec got=%b exp=0110", {done, cfg_ready, cnt_ncs, err_flag}); end
        step();
        checks++; if (done !== 1'b0) begin failures++;
            $display("FAIL abort_over_ec_late got=%b exp=0", done); end
    endtask

    task automatic test_cnt_err();
        run_to_run(8'd100, 8'd150, 8'd50, 8'd2);
        step(); step();  // T12
        cnt_err = 1'b1;
        step();
        cnt_err = 1'b0;
        checks++; if ({err_flag, cfg_ready, done, cnt_ncs} !== 4'b1101) begin failures++;
            $display("FAIL err_run got=%b exp=1101", {err_flag, cfg_ready, done, cnt_ncs}); end
        step();
        checks++; if ({done, err_flag} !== 2'b01) begin failures++;
            $display("FAIL err_no_done got=%b exp=01", {done, err_flag}); end
        // ec and err together: err wins.
        run_to_run(8'd100, 8'd150, 8'd50, 8'd2);
        checks++; if (err_flag !== 1'b0) begin failures++;
            $display("FAIL err_cleared got=%b exp=0", err_flag); end
        cnt_ec = 1'b1;
        cnt_err = 1'b1;
        step();
        cnt_ec = 1'b0;
        cnt_err = 1'b0;
        checks++; if ({err_flag, done, cfg_ready} !== 3'b101) begin failures++;
            $display("FAIL err_and_ec got=%b exp=101", {err_flag, done, cfg_ready}); end
        step();
        checks++; if (done !== 1'b0) begin failures++;
            $display("FAIL err_and_ec_late got=%b exp=0", done); end
        // Abort leaves ERR but keeps err_flag.
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({err_flag, cfg_ready, bus} !== {2'b11, BUS_IDLE}) begin failures++;
            $display("FAIL err_abort got=%b exp=%b", {err_flag, cfg_ready, bus}, {2'b11, BUS_IDLE}); end
    endtask

    task automatic test_async_reset();
        plr_in = 8'd100; ulr_in = 8'd150; llr_in = 8'd50; ccr_in = 8'd2;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (6) step();  // T7
        checks++; if (cnt_ncs !== 1'b0) begin failures++;
            $display("FAIL arst_busy got=%b exp=0", cnt_ncs); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({bus, cnt_doe, cnt_start, done, rd_valid, err_flag} !== {BUS_IDLE, 5'b00000})
        begin failures++;
            $display("FAIL arst_strobes got=%b exp=%b",
                     {bus, cnt_doe, cnt_start, done, rd_valid, err_flag}, {BUS_IDLE, 5'b00000}); end
        checks++; if ({cnt_dout, rd_data, cfg_ready} !== {16'h0000, 1'b1}) begin failures++;
            $display("FAIL arst_data got=%h/%h/%b exp=00/00/1", cnt_dout, rd_data, cfg_ready); end
        #2;
        reset = 1'b1;
        step();
        run_to_run(8'd8, 8'd8, 8'd0, 8'd3);  // plr == ulr is legal
        checks++; if ({cnt_ncs, cfg_ready, err_flag} !== 3'b000) begin failures++;
            $display("FAIL arst_rerun got=%b exp=000", {cnt_ncs, cfg_ready, err_flag}); end
        cnt_ec = 1'b1;
        step();
        cnt_ec = 1'b0;
        checks++; if (done !== 1'b1) begin failures++;
            $display("FAIL arst_done got=%b exp=1", done); end
        step();
        checks++; if ({done, cfg_ready} !== 2'b01) begin failures++;
            $display("FAIL arst_idle got=%b exp=01", {done, cfg_ready}); end
    endtask

    initial begin
        test_reset();
        test_valid_cfg();
        test_bad_limits();
        test_read_run();
        test_back_to_back();
        test_abort();
        test_cnt_err();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
